// File: rtl/max_track_stream.sv
// Streaming arg-max/arg-min tracker: scans a valid/ready frame of unsigned samples
// and presents the extreme value, its index and the beat count once per frame.
module max_track_stream #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode_min,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

  state_t state_reg, state_next;

  logic             mode_reg;
  logic [WIDTH-1:0] best_reg, best_next;
  logic [IDX_W-1:0] best_idx_reg, best_idx_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] out_value_reg;
  logic [IDX_W-1:0] out_index_reg;
  logic [IDX_W-1:0] out_count_reg;
  logic             out_ovf_reg;

  logic accept;
  logic first_beat;
  logic mode_eff;
  logic better;
  logic cnt_sat;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE, ACCUM: in_ready = !rst;
      HOLD:        out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Per-beat update: the first beat seeds the tracker, later beats compare strictly
  // so that ties keep the earliest position.
  always_comb begin
    first_beat = (state_reg == IDLE);
    mode_eff   = first_beat ? mode_min : mode_reg;
    better     = mode_eff ? (in_data < best_reg) : (in_data > best_reg);
    cnt_sat    = (cnt_reg == CNT_MAX);

    if (first_beat) begin
      best_next     = in_data;
      best_idx_next = '0;
      cnt_next      = CNT_ONE;
      ovf_next      = 1'b0;
    end else begin
      best_next     = better ? in_data : best_reg;
      best_idx_next = better ? cnt_reg : best_idx_reg;
      cnt_next      = cnt_sat ? cnt_reg : cnt_reg + CNT_ONE;
      ovf_next      = ovf_reg | cnt_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg      <= 1'b0;
      best_reg      <= '0;
      best_idx_reg  <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_value_reg <= '0;
      out_index_reg <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else if (accept) begin
      if (first_beat) begin
        mode_reg <= mode_min;
      end
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      // Result registers capture on the last-beat edge and persist past the handshake
      if (in_last) begin
        out_value_reg <= best_next;
        out_index_reg <= best_idx_next;
        out_count_reg <= cnt_next;
        out_ovf_reg   <= ovf_next;
      end
    end
  end

  assign out_value = out_value_reg;
  assign out_index = out_index_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

endmodule
